// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-ported register file with pending-write scoreboard
// Register 0 is constant zero. Reads are registered and see same-edge writes and reserves.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int SIZE   = 2**ADDR_W,
    parameter int NRD    = 2,
    parameter int NWR    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    output logic [NRD-1:0]          rd_busy,
    input  logic [NWR-1:0]          wr_en,
    input  logic [NWR*ADDR_W-1:0]   wr_addr,
    input  logic [NWR*DATA_W-1:0]   wr_data,
    input  logic                    rsv_en,
    input  logic [ADDR_W-1:0]       rsv_addr,
    output logic                    busy_any
);

    logic [DATA_W-1:0]     mem_q [1:SIZE-1];
    logic [DATA_W-1:0]     mem_d [SIZE];
    logic [SIZE-1:1]       busy_q;
    logic [SIZE-1:0]       busy_d;
    logic [NRD*DATA_W-1:0] rd_data_d;
    logic [NRD-1:0]        rd_busy_d;
    logic                  busy_any_d;

    // mem_d is the post-write view; reading it gives forwarding and port priority for free.
    always_comb begin
        mem_d[0] = '0;
        for (int r = 1; r < SIZE; r++) begin
            mem_d[r] = mem_q[r];
        end
        busy_d = {busy_q, 1'b0};
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] != '0)) begin
                mem_d[wr_addr[p*ADDR_W +: ADDR_W]]  = wr_data[p*DATA_W +: DATA_W];
                busy_d[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        // A new producer supersedes the one completing on the same edge.
        if (rsv_en && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        for (int i = 0; i < NRD; i++) begin
            if (rd_addr[i*ADDR_W +: ADDR_W] == '0) begin
                rd_data_d[i*DATA_W +: DATA_W] = '0;
                rd_busy_d[i]                  = 1'b0;
            end else begin
                rd_data_d[i*DATA_W +: DATA_W] = mem_d[rd_addr[i*ADDR_W +: ADDR_W]];
                rd_busy_d[i]                  = busy_d[rd_addr[i*ADDR_W +: ADDR_W]];
            end
        end
        busy_any_d = |busy_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 1; r < SIZE; r++) begin
                mem_q[r] <= '0;
            end
            busy_q   <= '0;
            rd_data  <= '0;
            rd_busy  <= '0;
            busy_any <= 1'b0;
        end else if (en) begin
            for (int r = 1; r < SIZE; r++) begin
                mem_q[r] <= mem_d[r];
            end
            busy_q   <= busy_d[SIZE-1:1];
            rd_data  <= rd_data_d;
            rd_busy  <= rd_busy_d;
            busy_any <= busy_any_d;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp
// Reference model tracks architectural state per address; literal checks pin it.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        rsv_en = 1'b0;
    logic [4:0]  rsv_addr = '0;
    logic        busy_any;

    int n_checks = 0;
    int n_fail = 0;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .NWR(2)) dut (
        .clk(clk), .rst(rst), .en(en),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_any(busy_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural contents and busy flags per address.
    logic [31:0] m_mem [32];
    logic        m_busy [32];
    logic [31:0] n_mem [32];
    logic        n_busy [32];
    logic [31:0] exp_rd [2];
    logic        exp_rb [2];
    logic        exp_any;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < 32; a++) begin
                m_mem[a]  = 32'h0;
                m_busy[a] = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                exp_rd[i] = 32'h0;
                exp_rb[i] = 1'b0;
            end
            exp_any = 1'b0;
        end else if (en) begin
            exp_any = 1'b0;
            for (int a = 0; a < 32; a++) begin
                int winner;
                winner = -1;
                for (int p = 0; p < 2; p++) begin
                    if (wr_en[p] && (int'(wr_addr[p*5 +: 5]) == a)) winner = p;
                end
                if (a == 0) begin
                    n_mem[a]  = 32'h0;
                    n_busy[a] = 1'b0;
                end else begin
                    n_mem[a]  = (winner >= 0) ? wr_data[winner*32 +: 32] : m_mem[a];
                    if (rsv_en && (int'(rsv_addr) == a)) n_busy[a] = 1'b1;
                    else if (winner >= 0)                n_busy[a] = 1'b0;
                    else                                 n_busy[a] = m_busy[a];
                end
                exp_any = exp_any | n_busy[a];
            end
            for (int i = 0; i < 2; i++) begin
                exp_rd[i] = n_mem[rd_addr[i*5 +: 5]];
                exp_rb[i] = n_busy[rd_addr[i*5 +: 5]];
            end
            m_mem  = n_mem;
            m_busy = n_busy;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                chk("model rd_data", rd_data[i*32 +: 32], exp_rd[i]);
                chk("model rd_busy", {31'h0, rd_busy[i]}, {31'h0, exp_rb[i]});
            end
            chk("model busy_any", {31'h0, busy_any}, {31'h0, exp_any});
        end
    end

    task automatic step(input logic e, input logic [1:0] we,
                        input logic [4:0] wa0, input logic [31:0] wd0,
                        input logic [4:0] wa1, input logic [31:0] wd1,
                        input logic rs, input logic [4:0] ra,
                        input logic [4:0] r0, input logic [4:0] r1);
        en       = e;
        wr_en    = we;
        wr_addr  = {wa1, wa0};
        wr_data  = {wd1, wd0};
        rsv_en   = rs;
        rsv_addr = ra;
        rd_addr  = {r1, r0};
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        chk("reset rd_data0", rd_data[31:0], 32'h0);
        chk("reset busy_any", {31'h0, busy_any}, 32'h0);

        // write r5, read it back, then asynchronous reset mid-cycle
        step(1, 2'b01, 5, 32'h1234, 0, 0, 0, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0, 0, 0, 0, 5, 5);
        chk("r5 before reset", rd_data[31:0], 32'h1234);
        rst = 1'b1;
        #1;
        chk("async clr rd_data0", rd_data[31:0], 32'h0);
        chk("async clr rd_data1", rd_data[63:32], 32'h0);
        chk("async clr rd_busy", {30'h0, rd_busy}, 32'h0);
        chk("async clr busy_any", {31'h0, busy_any}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        step(1, 2'b00, 0, 0, 0, 0, 0, 0, 5, 5);
        chk("r5 after reset p0", rd_data[31:0], 32'h0);
        chk("r5 after reset p1", rd_data[63:32], 32'h0);

        // write/read and x0
        step(1, 2'b01, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0, 0, 0, 0, 3, 0);
        chk("r3 read", rd_data[31:0], 32'hDEADBEEF);
        chk("r0 read", rd_data[63:32], 32'h0);
        step(1, 2'b01, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 3);
        step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0 after write", rd_data[31:0], 32'h0);

        // forwarding and write-port priority
        step(1, 2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 7, 3);
        chk("r7 forward", rd_data[31:0], 32'h22);
        step(1, 2'b00, 0, 0, 0, 0, 0, 0, 7, 7);
        chk("r7 stored", rd_data[63:32], 32'h22);

        // scoreboard
        step(1, 2'b00, 0, 0, 0, 0, 1, 9, 0, 0);
        step(1, 2'b00, 0, 0, 0, 0, 0, 0, 9, 0);
        chk("r9 busy", {31'h0, rd_busy[0]}, 32'h1);
        chk("busy_any set", {31'h0, busy_any}, 32'h1);
        step(1, 2'b01, 9, 32'h55, 0, 0, 0, 0, 9, 0);
        chk("r9 wb data", rd_data[31:0], 32'h55);
        chk("r9 wb busy", {31'h0, rd_busy[0]}, 32'h0);
        chk("busy_any clr", {31'h0, busy_any}, 32'h0);

        // reserve and write together, then reserve of r0
        step(1, 2'b01, 9, 32'h66, 0, 0, 1, 9, 9, 9);
        chk("r9 rsv+wr data", rd_data[31:0], 32'h66);
        chk("r9 rsv+wr busy", {31'h0, rd_busy[1]}, 32'h1);
        step(1, 2'b10, 0, 0, 9, 32'h66, 0, 0, 9, 0);
        step(1, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("rsv r0 busy_any", {31'h0, busy_any}, 32'h0);

        // enable stall
        step(1, 2'b01, 4, 32'h44, 0, 0, 0, 0, 4, 0);
        step(0, 2'b01, 4, 32'h77, 0, 0, 1, 4, 3, 7);
        chk("stall rd_data0", rd_data[31:0], 32'h44);
        chk("stall rd_data1", rd_data[63:32], 32'h0);
        chk("stall busy_any", {31'h0, busy_any}, 32'h0);
        step(0, 2'b11, 4, 32'h77, 5, 32'h99, 1, 5, 7, 3);
        step(1, 2'b00, 0, 0, 0, 0, 0, 0, 4, 4);
        chk("r4 after stall", rd_data[63:32], 32'h44);
        chk("r4 not busy", {30'h0, rd_busy}, 32'h0);

        // mixed traffic checked by the model only
        for (int k = 0; k < 12; k++) begin
            step(1, 2'(k % 4), 5'(k + 1), 32'hA000 + k, 5'(k + 2), 32'hB000 + k,
                 k[0], 5'(k * 3), 5'(k + 1), 5'(k * 3));
        end
        step(1, 2'b00, 0, 0, 0, 0, 0, 0, 2, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
